// File: rtl/alarm_sounder.sv
// Alarm sounder: turns the comparator's alarming level into grouped beeps
// on a piezo output and returns a debounced dismiss level.
module alarm_sounder #(
    parameter int DEB_CYCLES = 20,
    parameter int TONE_HALF  = 25000,
    parameter int BEEP_ON    = 10000000,
    parameter int BEEP_OFF   = 5000000,
    parameter int BEEPS      = 3,
    parameter int GROUP_GAP  = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic alarming,
    input  logic btn_off,
    output logic buzzer,
    output logic off,
    output logic alarm_led
);

    localparam int M1 = (DEB_CYCLES > TONE_HALF) ? DEB_CYCLES : TONE_HALF;
    localparam int M2 = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int M3 = (BEEPS > GROUP_GAP) ? BEEPS : GROUP_GAP;
    localparam int M4 = (M1 > M2) ? M1 : M2;
    localparam int MAXP = (M3 > M4) ? M3 : M4;
    localparam int CW = $clog2(MAXP + 1);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    typedef enum logic [2:0] {
        IDLE,
        BEEP,
        SPACE,
        GAP,
        ACKED
    } state_t;

    state_t state;
    state_t state_n;

    logic al_q1;
    logic al_s;
    logic btn_q1;
    logic btn_s;
    logic btn_db;
    logic btn_db_q;
    logic press;

    cnt_t deb_cnt;
    cnt_t phase;
    cnt_t tone_cnt;
    cnt_t beep_cnt;
    cnt_t beep_n;

    assign press = btn_db & ~btn_db_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            al_q1    <= 1'b0;
            al_s     <= 1'b0;
            btn_q1   <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            al_q1    <= alarming;
            al_s     <= al_q1;
            btn_q1   <= btn_off;
            btn_s    <= btn_q1;
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt + ONE == cnt_t'(DEB_CYCLES - 1)) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + ONE;
            end
        end
    end

    // Window end beats a press, and a press beats a phase expiry.
    always_comb begin
        state_n = state;
        beep_n  = beep_cnt;
        unique case (state)
            IDLE: begin
                if (al_s) begin
                    state_n = BEEP;
                    beep_n  = '0;
                end
            end
            BEEP: begin
                if (!al_s) begin
                    state_n = IDLE;
                end else if (press) begin
                    state_n = ACKED;
                end else if (phase == cnt_t'(BEEP_ON - 1)) begin
                    if (beep_cnt < cnt_t'(BEEPS - 1)) begin
                        state_n = SPACE;
                        beep_n  = beep_cnt + ONE;
                    end else begin
                        state_n = GAP;
                        beep_n  = '0;
                    end
                end
            end
            SPACE: begin
                if (!al_s) begin
                    state_n = IDLE;
                end else if (press) begin
                    state_n = ACKED;
                end else if (phase == cnt_t'(BEEP_OFF - 1)) begin
                    state_n = BEEP;
                end
            end
            GAP: begin
                if (!al_s) begin
                    state_n = IDLE;
                end else if (press) begin
                    state_n = ACKED;
                end else if (phase == cnt_t'(GROUP_GAP - 1)) begin
                    state_n = BEEP;
                end
            end
            ACKED: begin
                if (!al_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (state_n == IDLE || state_n == ACKED) begin
            beep_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beep_cnt  <= '0;
            phase     <= '0;
            tone_cnt  <= '0;
            buzzer    <= 1'b0;
            alarm_led <= 1'b0;
            off       <= 1'b0;
        end else begin
            state    <= state_n;
            beep_cnt <= beep_n;

            if (state_n != state) begin
                phase <= '0;
            end else if (state inside {BEEP, SPACE, GAP}) begin
                phase <= phase + ONE;
            end else begin
                phase <= '0;
            end

            if (state == BEEP && state_n == BEEP) begin
                if (tone_cnt == cnt_t'(TONE_HALF - 1)) begin
                    tone_cnt <= '0;
                    buzzer   <= ~buzzer;
                end else begin
                    tone_cnt <= tone_cnt + ONE;
                end
            end else begin
                tone_cnt <= '0;
                buzzer   <= 1'b0;
            end

            alarm_led <= (state_n inside {BEEP, SPACE, GAP});
            // Lags ACKED by one cycle so the level outlives the state.
            off       <= (state == ACKED);
        end
    end

endmodule

// File: tb/tb_alarm_sounder.sv
// Scoreboard bench for alarm_sounder: per-cycle expected outputs are
// queued with the stimulus and compared on the falling edge.
module tb_alarm_sounder;

    localparam int DEB = 4;
    localparam int TH  = 2;
    localparam int BON = 8;
    localparam int BOF = 4;
    localparam int NB  = 3;
    localparam int GG  = 12;
    localparam int PER = NB * BON + (NB - 1) * BOF + GG;

    logic clk;
    logic rst;
    logic alarming;
    logic btn_off;
    logic buzzer;
    logic off;
    logic alarm_led;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    alarm_sounder #(
        .DEB_CYCLES(DEB),
        .TONE_HALF (TH),
        .BEEP_ON   (BON),
        .BEEP_OFF  (BOF),
        .BEEPS     (NB),
        .GROUP_GAP (GG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alarming (alarming),
        .btn_off  (btn_off),
        .buzzer   (buzzer),
        .off      (off),
        .alarm_led(alarm_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got,
                       input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s led/buz/off got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Expected {led, buzzer, off} k cycles after BEEP entry.
    function automatic logic [2:0] pat(input int k);
        int p;
        int o;
        p = k % PER;
        o = -1;
        for (int b = 0; b < NB; b++) begin
            if (p >= b * (BON + BOF) && p < b * (BON + BOF) + BON) begin
                o = p - b * (BON + BOF);
            end
        end
        return {1'b1, (o >= 0) && (((o / TH) % 2) == 1), 1'b0};
    endfunction

    task automatic tick(input logic [2:0] e, input string tag);
        @(posedge clk);
        #1;
        sb.push_back('{tag: tag, exp: e});
    endtask

    task automatic run_pat(input int k0, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(pat(k0 + i), $sformatf("%s k%0d", tag, k0 + i));
        end
    endtask

    task automatic run_const(input logic [2:0] e, input int n,
                             input string tag);
        for (int i = 0; i < n; i++) begin
            tick(e, $sformatf("%s %0d", tag, i));
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, {alarm_led, buzzer, off}, mon_e.exp);
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        alarming = 1'b0;
        btn_off  = 1'b0;

        run_const(3'b000, 3, "reset");
        rst = 1'b0;
        run_const(3'b000, 2, "idle");

        // Free-running pattern, then end the window during a SPACE.
        alarming = 1'b1;
        run_const(3'b000, 2, "lat");
        run_pat(0, 98, "pat");
        alarming = 1'b0;
        run_pat(98, 2, "endsync");
        run_const(3'b000, 5, "ended");

        // Re-raise restarts at beep 0; dismiss during beep 2.
        alarming = 1'b1;
        run_const(3'b000, 2, "relat");
        run_pat(0, 26, "repat");
        btn_off = 1'b1;
        run_pat(26, 5, "deb");
        run_const(3'b000, 1, "ack");
        run_const(3'b001, 4, "off");
        btn_off = 1'b0;
        run_const(3'b001, 6, "hold");
        alarming = 1'b0;
        run_const(3'b001, 3, "offlag");
        run_const(3'b000, 4, "offdrop");

        // Bounce never produces a press.
        alarming = 1'b1;
        run_const(3'b000, 2, "blat");
        run_pat(0, 7, "bpat");
        for (int i = 0; i < 20; i++) begin
            btn_off = ((i / 2) % 2) == 0;
            tick(pat(7 + i), $sformatf("bounce k%0d", 7 + i));
        end
        btn_off = 1'b0;
        run_pat(27, 20, "bpost");

        // Press lands on the same cycle al_s falls.
        btn_off = 1'b1;
        run_pat(47, 3, "pri");
        alarming = 1'b0;
        run_pat(50, 2, "pri");
        run_const(3'b000, 6, "prio");
        btn_off = 1'b0;
        run_const(3'b000, 8, "prrel");

        // Synchronous reset mid-BEEP.
        alarming = 1'b1;
        run_const(3'b000, 2, "rlat");
        run_pat(0, 4, "rpat");
        rst = 1'b1;
        run_const(3'b000, 1, "rst");
        rst = 1'b0;
        run_const(3'b000, 2, "rrel");
        run_pat(0, 12, "rre");

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
